fix_query_arbiter: RTL and testbench
====================================

# fix_query_arbiter

Round-robin scheduler that shares the parser's single tag-lookup port (find tag / message number / read-message strobe → value RAM read) among NUM_REQ independent query clients. It accepts one lookup at a time, drives the parser top's query inputs, waits for the value-valid return, and routes the 256-bit value back to the granted client with its ID. It sits between downstream consumers (order book, risk check, logger) and the parser top.

## Interface
- NUM_REQ, 4: number of query clients (2–8).
- MSG_W, 10: message-number width; matches the parser top's message-number input.
- TIMEOUT_CYCLES, 64: WAIT-state abort limit (used only with the timeout macro).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-client request level; held until its grant.
- req_tag_i  in  NUM_REQ*32  per-client tag; client k occupies bits [32k+31:32k].
- req_msg_i  in  NUM_REQ*MSG_W  per-client message number, packed the same way.
- gnt_o  out  NUM_REQ  one-hot, one-cycle grant pulse.
- find_tag_o  out  32  to parser top find-tag input.
- message_num_o  out  MSG_W  to parser top message-number input.
- read_message_o  out  1  one-cycle strobe to the parser top read-message input.
- empty_i  in  1  parser store empty.
- value_i  in  256  parser output value.
- value_valid_i  in  1  parser output-value-valid.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_id_o  out  $clog2(NUM_REQ)  client ID of the response.
- rsp_hit_o  out  1  1 = value returned; 0 = miss (empty or timeout).
- rsp_value_o  out  256  returned value; zero on a miss.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any req_i is high, select the first requester at or after rr_ptr (cyclic).
  - Register its tag and message number into find_tag_o and message_num_o.
  - Pulse gnt_o.
  - If empty_i is high: go to RESP with a miss. Otherwise go to ISSUE.
- ISSUE
  - read_message_o = 1 for exactly this cycle.
  - Go to WAIT.
- WAIT
  - Hold find_tag_o and message_num_o stable.
  - On value_valid_i: capture value_i, set hit = 1, go to RESP.
- RESP
  - rsp_valid_o = 1, with rsp_id_o = granted ID.
  - Set rr_ptr = (granted ID + 1) mod NUM_REQ.
  - Go to IDLE.
- A client must keep req_i high until it sees its gnt_o bit. The client drops req_i in the cycle after the grant.
- A req_i still high when IDLE is re-entered is treated as a new request.
- value_valid_i outside WAIT is ignored.
- Requests raised during ISSUE, WAIT or RESP wait for IDLE. No request is lost or reordered beyond round-robin order.
- Reset, including mid-transaction:
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: gnt_o, read_message_o, rsp_valid_o, rsp_hit_o, busy_o, find_tag_o, message_num_o, rsp_value_o, rsp_id_o.
  - Any in-flight query is dropped and no response is issued.
  - A late value_valid_i after reset is ignored.

## Timing
- All outputs are registered.
- req_i seen at edge t produces gnt_o during cycle t+1 (the IDLE→ISSUE transition).
- read_message_o is asserted in cycle t+2.
- value_valid_i sampled high at edge v produces rsp_valid_o in cycle v+1, with rsp_value_o valid for that same cycle.
- Empty case: gnt_o in cycle t+1, miss response in cycle t+2, and no read_message_o.
- Minimum spacing between consecutive grants is 4 cycles: IDLE, ISSUE, WAIT(≥1), RESP.
- busy_o rises with the grant cycle and falls in the cycle after RESP.

## Configuration
- FIX_QUERY_TIMEOUT_EN defined:
  - An 8-bit-or-wider wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES with no value_valid_i, go to RESP with a miss (rsp_hit_o = 0, rsp_value_o = 0).
  - If value_valid_i arrives on the same cycle the limit is reached, the hit wins.
- Undefined: no counter; WAIT waits indefinitely for value_valid_i.

## Test plan
- Single request: client 2, tag 0x00000023, msg 3, empty_i = 0; value_valid_i 5 cycles after strobe with value 0xABCD → gnt_o = 4'b0100, one read_message_o pulse with find_tag_o = 0x23, then rsp_valid_o, rsp_id_o = 2, rsp_hit_o = 1, rsp_value_o = 0xABCD.
- Fairness: all four req_i held continuously → grants in order 0,1,2,3,0, each response ID matching its grant.
- Empty store: empty_i = 1 and client 1 requests → gnt then miss response the next cycle (rsp_hit_o = 0, value 0), read_message_o never asserted.
- Timeout (macro defined, TIMEOUT_CYCLES = 64): no value_valid_i → miss response exactly 64 WAIT cycles after the strobe. Without the macro, busy_o stays high for at least 200 cycles.
- Reset mid-WAIT: assert rst, then deliver value_valid_i after release → no rsp_valid_o, all outputs 0, and the next request is granted starting from client 0.
- Stray valid: value_valid_i pulsed in IDLE → no response, state unchanged.

Source files
------------

// File: rtl/fix_query_arbiter.sv
// Round-robin arbiter sharing the parser's single tag-lookup port among NUM_REQ query clients.
// Optional WAIT-state abort is compiled in when FIX_QUERY_TIMEOUT_EN is defined.
module fix_query_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MSG_W          = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*32-1:0]        req_tag_i,
  input  logic [NUM_REQ*MSG_W-1:0]     req_msg_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [31:0]                  find_tag_o,
  output logic [MSG_W-1:0]             message_num_o,
  output logic                         read_message_o,
  input  logic                         empty_i,
  input  logic [255:0]                 value_i,
  input  logic                         value_valid_i,
  output logic                         rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic                         rsp_hit_o,
  output logic [255:0]                 rsp_value_o,
  output logic                         busy_o
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]        find_tag_q, find_tag_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               read_q, read_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic [255:0]       rsp_value_q, rsp_value_d;
  logic               busy_q, busy_d;

  logic [31:0]        tag_arr [NUM_REQ];
  logic [MSG_W-1:0]   msg_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign tag_arr[gi] = req_tag_i[32*gi +: 32];
    assign msg_arr[gi] = req_msg_i[MSG_W*gi +: MSG_W];
  end

  // Scan from the farthest offset down so the closest requester at/after rr_ptr wins.
  logic [IDW-1:0] sel_id;
  always_comb begin
    sel_id = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        sel_id = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

`ifdef FIX_QUERY_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_d       = '0;
    find_tag_d  = find_tag_q;
    msg_d       = msg_q;
    read_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_value_d = '0;
`ifdef FIX_QUERY_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_id_d       = sel_id;
          gnt_d[sel_id]  = 1'b1;
          find_tag_d     = tag_arr[sel_id];
          msg_d          = msg_arr[sel_id];
          state_d        = empty_i ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        read_d  = 1'b1;
        state_d = WAIT;
`ifdef FIX_QUERY_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        // Response is registered on the way into RESP so it shows one cycle after value_valid_i.
        if (value_valid_i) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_value_d = value_i;
          state_d     = RESP;
`ifdef FIX_QUERY_TIMEOUT_EN
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        // Arriving straight from IDLE (empty store) the miss has not been sent yet.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end
        rr_ptr_d = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_id_d = rsp_valid_d ? gnt_id_q : '0;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      gnt_q       <= '0;
      find_tag_q  <= '0;
      msg_q       <= '0;
      read_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_value_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_q       <= gnt_d;
      find_tag_q  <= find_tag_d;
      msg_q       <= msg_d;
      read_q      <= read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_value_q <= rsp_value_d;
      busy_q      <= busy_d;
    end
  end

`ifdef FIX_QUERY_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign gnt_o          = gnt_q;
  assign find_tag_o     = find_tag_q;
  assign message_num_o  = msg_q;
  assign read_message_o = read_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_hit_o      = rsp_hit_q;
  assign rsp_value_o    = rsp_value_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_fix_query_arbiter.sv
// Directed bench for fix_query_arbiter: single hit, fairness, empty store, stray valid,
// reset mid-WAIT and WAIT timeout / no-timeout behaviour.
module tb_fix_query_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MSG_W   = 10;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*32-1:0]    req_tag;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [31:0]              find_tag_o;
  logic [MSG_W-1:0]         message_num_o;
  logic                     read_message_o;
  logic                     empty;
  logic [255:0]             value;
  logic                     vv;
  logic                     rsp_valid_o;
  logic [1:0]               rsp_id_o;
  logic                     rsp_hit_o;
  logic [255:0]             rsp_value_o;
  logic                     busy_o;

  fix_query_arbiter #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .req_tag_i(req_tag), .req_msg_i(req_msg),
    .gnt_o(gnt_o), .find_tag_o(find_tag_o), .message_num_o(message_num_o),
    .read_message_o(read_message_o), .empty_i(empty),
    .value_i(value), .value_valid_i(vv),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_hit_o(rsp_hit_o),
    .rsp_value_o(rsp_value_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int k, input logic [31:0] tag, input logic [MSG_W-1:0] msg);
    req_tag[32*k +: 32]       = tag;
    req_msg[MSG_W*k +: MSG_W] = msg;
  endtask

  initial begin
    int          waited;
    int          bad;
    logic [3:0]  exp_g;
    logic [1:0]  exp_id;
    logic [15:0] exp_v;

    req = '0; req_tag = '0; req_msg = '0; empty = 1'b0; value = '0; vv = 1'b0;
    set_client(0, 32'h0000_0010, 10'd1);
    set_client(1, 32'h0000_0011, 10'd2);
    set_client(2, 32'h0000_0023, 10'd3);
    set_client(3, 32'h0000_0013, 10'd4);

    // Reset state
    tick(); tick();
    chk("rst_ctl", {gnt_o, read_message_o, rsp_valid_o, rsp_hit_o, busy_o, rsp_id_o}, '0);
    chk("rst_tag_msg", {find_tag_o, message_num_o}, '0);
    chk("rst_value", rsp_value_o, '0);
    rst = 1'b0;
    tick();

    // Fairness: all clients held high -> grants 0,1,2,3,0
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g  = 4'b0001 << (g % 4);
      exp_id = 2'(g % 4);
      exp_v  = 16'h0100 + 16'(g);
      waited = 0;
      tick();
      while (gnt_o == '0 && waited < 20) begin tick(); waited++; end
      chk("fair_gnt", gnt_o, exp_g);
      chk("fair_busy", busy_o, 1'b1);
      waited = 0;
      tick();
      chk("fair_gnt_pulse", gnt_o, '0);
      while (!read_message_o && waited < 20) begin tick(); waited++; end
      chk("fair_read", read_message_o, 1'b1);
      vv = 1'b1; value = 256'(exp_v);
      tick();
      vv = 1'b0; value = '0;
      if (g == 4) req = '0;
      chk("fair_rsp", {rsp_valid_o, rsp_hit_o, rsp_id_o, rsp_value_o[15:0]}, {1'b1, 1'b1, exp_id, exp_v});
    end
    tick(); tick();
    chk("fair_idle", {busy_o, gnt_o, rsp_valid_o}, '0);

    // Single request: client 2, value 5 cycles after strobe
    req = 4'b0100;
    tick();
    chk("single_gnt", gnt_o, 4'b0100);
    chk("single_tag", find_tag_o, 32'h23);
    chk("single_msg", message_num_o, 10'd3);
    chk("single_early_read", {read_message_o, busy_o}, 2'b01);
    req = '0;
    tick();
    chk("single_read", {read_message_o, find_tag_o}, {1'b1, 32'h23});
    tick();
    chk("single_read_pulse", read_message_o, 1'b0);
    tick(); tick(); tick();
    chk("single_waiting", {rsp_valid_o, busy_o}, 2'b01);
    tick();
    vv = 1'b1; value = 256'hABCD;
    tick();
    vv = 1'b0; value = '0;
    chk("single_rsp", {rsp_valid_o, rsp_hit_o, rsp_id_o}, 4'b1110);
    chk("single_value", rsp_value_o, 256'hABCD);
    tick();
    chk("single_done", {rsp_valid_o, busy_o}, 2'b00);

    // Stray value_valid in IDLE
    vv = 1'b1; value = 256'h55;
    tick();
    vv = 1'b0; value = '0;
    chk("stray_a", {rsp_valid_o, busy_o, read_message_o, gnt_o}, '0);
    tick();
    chk("stray_b", {rsp_valid_o, busy_o, read_message_o, gnt_o}, '0);

    // Empty store: client 1, miss next cycle, no strobe
    empty = 1'b1;
    req = 4'b0010;
    tick();
    chk("empty_gnt", {gnt_o, read_message_o, busy_o}, 6'b0010_0_1);
    req = '0;
    tick();
    chk("empty_rsp", {rsp_valid_o, rsp_hit_o, rsp_id_o, read_message_o}, 5'b1_0_01_0);
    chk("empty_value", rsp_value_o, '0);
    tick();
    chk("empty_done", {rsp_valid_o, read_message_o, busy_o}, 3'b000);
    empty = 1'b0;

    // Reset mid-WAIT on client 3, late valid afterwards
    req = 4'b1000;
    tick();
    chk("rstw_gnt", gnt_o, 4'b1000);
    req = '0;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_async_ctl", {gnt_o, read_message_o, rsp_valid_o, rsp_hit_o, busy_o, rsp_id_o}, '0);
    chk("rstw_async_tag", {find_tag_o, message_num_o}, '0);
    tick();
    rst = 1'b0;
    vv = 1'b1; value = 256'hDEAD;
    tick();
    vv = 1'b0; value = '0;
    chk("rstw_late_valid", {rsp_valid_o, busy_o, rsp_value_o[15:0]}, '0);
    tick();
    chk("rstw_quiet", {rsp_valid_o, busy_o, gnt_o}, '0);
    req = 4'b1010;
    tick();
    chk("rstw_ptr0_gnt", gnt_o, 4'b0010);
    req = '0;
    waited = 0;
    while (!read_message_o && waited < 20) begin tick(); waited++; end
    vv = 1'b1; value = 256'h77;
    tick();
    vv = 1'b0; value = '0;
    chk("rstw_rsp", {rsp_valid_o, rsp_hit_o, rsp_id_o, rsp_value_o[15:0]}, {1'b1, 1'b1, 2'd1, 16'h0077});

    // Timeout (or its absence) on client 0
    tick();
    req = 4'b0001;
    tick();
    chk("to_gnt", gnt_o, 4'b0001);
    req = '0;
    tick();
    chk("to_read", read_message_o, 1'b1);
`ifdef FIX_QUERY_TIMEOUT_EN
    waited = 0;
    while (!rsp_valid_o && waited < 100) begin tick(); waited++; end
    chk("to_delay", waited, 64);
    chk("to_miss", {rsp_valid_o, rsp_hit_o, rsp_id_o}, 4'b1000);
    chk("to_value", rsp_value_o, '0);
`else
    bad = 0;
    repeat (200) begin
      tick();
      if (!busy_o || rsp_valid_o) bad++;
    end
    chk("no_to_busy", bad, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
